chaotic_iter_ctrl: RTL and testbench
====================================

# chaotic_iter_ctrl

Iteration controller for a DIM-dimensional chaotic difference-equation core (forward-Euler x(n+1) = f(x(n))). It loads a seed state, issues iterations to the equation core, and feeds each result back as the next state. It discards a programmable number of warm-up iterations, then streams sample vectors through a valid/ready port. It sits between the parameter/seed registers and the downstream sequence generator, and replaces hand-wired feedback around the equation top level.

## Interface
- DATA_WIDTH, 64: per-lane word width; matches the floating-point IP width.
- DIM, 3: number of state variables (lanes); must be ≥ 1.
- ITER_W, 32: width of the warm-up, sample-count and index counters.
- TIMEOUT, 1024: maximum number of WAIT cycles before abort; used only with the watchdog macro.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; latches seed, warmup and num_samples.
- stop  in  1  single-cycle request to finish at the next iteration boundary.
- seed  in  DIM*DATA_WIDTH  initial state; lane i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- warmup  in  ITER_W  number of iterations to discard before the first sample.
- num_samples  in  ITER_W  number of samples to emit; 0 means free-run until stop.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- eq_valid  out  1  one-cycle issue strobe to the core (the core's n_valid).
- eq_state  out  DIM*DATA_WIDTH  current state presented to the core.
- eq_next_valid  in  1  core result strobe (the core's n1_valid).
- eq_next  in  DIM*DATA_WIDTH  core result.
- smp_valid  out  1  sample available.
- smp_ready  in  1  downstream accept.
- smp_data  out  DIM*DATA_WIDTH  sample vector (the state after the iteration).
- smp_index  out  ITER_W  0-based sample number; wraps in free-run mode.

## Operation
- FSM states: IDLE, ISSUE, WAIT, EMIT, DONE. All outputs are registered.
- IDLE: start loads state←seed and clears the counters, err and stop_pend. Next state is ISSUE.
- ISSUE: eq_valid=1 for exactly one cycle, with eq_state=state. Next state is WAIT.
- WAIT: on eq_next_valid, state←eq_next. Then:
  - if warm_cnt < warmup: warm_cnt++; go to DONE if stop_pend, else ISSUE.
  - otherwise go to EMIT.
- EMIT: smp_valid=1, smp_data=state, smp_index=samp_cnt, all held stable until smp_ready. On handshake, samp_cnt++. Then:
  - DONE if num_samples≠0 and samp_cnt+1 = num_samples;
  - else DONE if stop_pend;
  - else ISSUE.
- DONE: done=1 for one cycle, busy drops, next state is IDLE.
- stop is latched into stop_pend in any non-IDLE state and is ignored in IDLE. An in-flight core iteration always completes.
- start while busy is ignored.
- eq_next_valid outside WAIT is ignored; state is unchanged.
- Counters are unsigned and wrap modulo 2^ITER_W.
- warmup=0 means the first iteration result is sample 0.
- Reset mid-operation: FSM returns to IDLE and all regs clear. A late core result arrives in IDLE and is dropped.

## Timing
- Reset values: busy, done, err, eq_valid, smp_valid = 0; eq_state, smp_data, smp_index = 0.
- start accepted at edge 0 → eq_valid and busy high in cycle 1.
- eq_next_valid in cycle t → smp_valid in cycle t+1 (sample iteration), or eq_valid in cycle t+1 (warm-up iteration).
- Handshake in cycle u → eq_valid in cycle u+1, or done in cycle u+1.
- Per-iteration cost: core latency L + 2 cycles + any backpressure. Only one iteration is ever in flight.

## Configuration
- CHAOS_ITER_TIMEOUT_EN defined:
  - a watchdog counts consecutive WAIT cycles;
  - at the count TIMEOUT with no eq_next_valid, err←1 and the FSM goes to DONE;
  - a result arriving in that same cycle wins.
- Undefined: err is tied to 0 and WAIT waits indefinitely.

## Structure
- chaos_pkg holds:
  - the FSM state enum;
  - the lane-slice localparam/function for the flattened buses;
  - the default DIM and DATA_WIDTH constants.
- One sub-module, chaos_iter_watchdog (counter, clear and expiry), instantiated only under CHAOS_ITER_TIMEOUT_EN.

## Test plan
Bench setup: DIM=3, DATA_WIDTH=64, and a model core with latency 5 that returns each lane +1.
- Warm-up and count: seed {0,0,0}, warmup=2, num_samples=3, smp_ready=1 → samples {3,3,3}, {4,4,4}, {5,5,5} with index 0..2, then a done pulse; eq_valid pulses 5 times in total.
- Backpressure: smp_ready low for 4 cycles on sample 1 → smp_valid, smp_data and smp_index held stable; the next eq_valid comes 1 cycle after the handshake.
- Free-run with stop: num_samples=0, stop pulsed mid-WAIT of sample 6 → sample 6 is still emitted, then done; no further eq_valid.
- Ignored inputs: start while busy and stray eq_next_valid in EMIT → no state change; the sample sequence is unchanged.
- Reset mid-WAIT: rst_n low for 1 cycle → all outputs 0 and FSM in IDLE; the late core result is dropped.
- Watchdog (macro defined, TIMEOUT=16): the core never responds → err=1 and done exactly 16 WAIT cycles after eq_valid; the next start clears err.

Source files
------------

// File: rtl/chaos_pkg.sv
// chaos_pkg: shared FSM encoding, lane helper and default sizes.
// Optional watchdog in the controller is enabled by CHAOS_ITER_TIMEOUT_EN.
package chaos_pkg;

  localparam int unsigned DEF_DIM        = 3;
  localparam int unsigned DEF_DATA_WIDTH = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } chaos_state_e;

  // LSB of lane `lane` in a flattened DIM*width bus.
  function automatic int unsigned lane_lsb(
    input int unsigned lane,
    input int unsigned width
  );
    return lane * width;
  endfunction

endpackage

// File: rtl/chaos_iter_watchdog.sv
// chaos_iter_watchdog: counts consecutive run cycles, flags expiry.
// Used by chaotic_iter_ctrl only when CHAOS_ITER_TIMEOUT_EN is defined.
module chaos_iter_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the TIMEOUT-th consecutive run cycle.
  assign expire_o = run_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/chaotic_iter_ctrl.sv
// chaotic_iter_ctrl: seed/issue/feedback loop around the equation core.
// Define CHAOS_ITER_TIMEOUT_EN to enable the WAIT watchdog and err flag.
module chaotic_iter_ctrl
  import chaos_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DIM        = DEF_DIM,
  parameter int unsigned ITER_W     = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [DIM*DATA_WIDTH-1:0] seed,
  input  logic [ITER_W-1:0]         warmup,
  input  logic [ITER_W-1:0]         num_samples,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      eq_valid,
  output logic [DIM*DATA_WIDTH-1:0] eq_state,
  input  logic                      eq_next_valid,
  input  logic [DIM*DATA_WIDTH-1:0] eq_next,
  output logic                      smp_valid,
  input  logic                      smp_ready,
  output logic [DIM*DATA_WIDTH-1:0] smp_data,
  output logic [ITER_W-1:0]         smp_index
);

  localparam int unsigned VW = DIM * DATA_WIDTH;

  chaos_state_e fsm_q, fsm_d;

  logic [VW-1:0]     vec_q, vec_d;
  logic [ITER_W-1:0] warm_q, warm_d;
  logic [ITER_W-1:0] samp_q, samp_d;
  logic [ITER_W-1:0] wup_q, wup_d;
  logic [ITER_W-1:0] nsmp_q, nsmp_d;
  logic              stop_q, stop_d;
  logic              err_q, err_d;

  logic busy_q, done_q, eqv_q, smpv_q;
  logic expire;

`ifdef CHAOS_ITER_TIMEOUT_EN
  chaos_iter_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (fsm_q == S_WAIT),
    .expire_o (expire)
  );
`else
  assign expire = (TIMEOUT == 0) & 1'b0;
`endif

  always_comb begin
    fsm_d  = fsm_q;
    vec_d  = vec_q;
    warm_d = warm_q;
    samp_d = samp_q;
    wup_d  = wup_q;
    nsmp_d = nsmp_q;
    err_d  = err_q;
    stop_d = stop_q | (stop && (fsm_q != S_IDLE));
    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          fsm_d  = S_ISSUE;
          vec_d  = seed;
          warm_d = '0;
          samp_d = '0;
          wup_d  = warmup;
          nsmp_d = num_samples;
          stop_d = 1'b0;
          err_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        fsm_d = S_WAIT;
      end
      S_WAIT: begin
        if (eq_next_valid) begin
          vec_d = eq_next;
          if (warm_q < wup_q) begin
            warm_d = warm_q + 1'b1;
            fsm_d  = stop_q ? S_DONE : S_ISSUE;
          end else begin
            fsm_d = S_EMIT;
          end
        end else if (expire) begin
          err_d = 1'b1;
          fsm_d = S_DONE;
        end
      end
      S_EMIT: begin
        if (smp_ready) begin
          samp_d = samp_q + 1'b1;
          // num_samples of zero means free-run until stop.
          if ((nsmp_q != '0) && (samp_d == nsmp_q)) begin
            fsm_d = S_DONE;
          end else if (stop_q) begin
            fsm_d = S_DONE;
          end else begin
            fsm_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        fsm_d = S_IDLE;
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= S_IDLE;
      vec_q  <= '0;
      warm_q <= '0;
      samp_q <= '0;
      wup_q  <= '0;
      nsmp_q <= '0;
      stop_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      eqv_q  <= 1'b0;
      smpv_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      vec_q  <= vec_d;
      warm_q <= warm_d;
      samp_q <= samp_d;
      wup_q  <= wup_d;
      nsmp_q <= nsmp_d;
      stop_q <= stop_d;
      err_q  <= err_d;
      busy_q <= fsm_d inside {S_ISSUE, S_WAIT, S_EMIT};
      done_q <= (fsm_d == S_DONE);
      eqv_q  <= (fsm_d == S_ISSUE);
      smpv_q <= (fsm_d == S_EMIT);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign eq_valid  = eqv_q;
  assign eq_state  = vec_q;
  assign smp_valid = smpv_q;
  assign smp_data  = vec_q;
  assign smp_index = samp_q;

`ifdef CHAOS_ITER_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0 & err_q;
`endif

endmodule

// File: tb/tb_chaotic_iter_ctrl.sv
// tb_chaotic_iter_ctrl: table, directed and random checks of the controller.
// Watchdog checks are compiled when CHAOS_ITER_TIMEOUT_EN is defined.
module tb_chaotic_iter_ctrl;
  import chaos_pkg::*;

  localparam int DW  = 64;
  localparam int D   = 3;
  localparam int IW  = 32;
  localparam int TO  = 16;
  localparam int LAT = 5;
  localparam int VW  = DW * D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [VW-1:0] seed = '0;
  logic [IW-1:0] warmup = '0;
  logic [IW-1:0] num_samples = '0;
  logic          busy, done, err, eq_valid, smp_valid;
  logic          eq_next_valid;
  logic          smp_ready;
  logic [VW-1:0] eq_state, eq_next, smp_data;
  logic [IW-1:0] smp_index;

  logic          core_v = 1'b0;
  logic          stray_v = 1'b0;
  logic          core_mute = 1'b0;
  logic [VW-1:0] core_data = '0;
  logic [VW-1:0] core_hold = '0;
  logic [VW-1:0] stray_data = '0;
  int            core_cnt = 0;

  bit rdy_rand = 0;
  bit rdy_hold = 0;
  int blk_idx = 0;
  int blk_left = 0;

  int total = 0;
  int bad = 0;
  int ev_cnt = 0;
  int done_cnt = 0;
  bit hs_pend = 0;
  bit res_pend = 0;
  bit prev_v = 0;
  bit prev_r = 0;
  bit prev_ev = 0;
  logic [VW-1:0] prev_d = '0;
  logic [IW-1:0] prev_i = '0;

  logic [VW-1:0] got_d[$];
  logic [IW-1:0] got_i[$];

  assign eq_next_valid = core_v | stray_v;
  assign eq_next = stray_v ? stray_data : core_data;

  always #5 clk = ~clk;

  chaotic_iter_ctrl #(
    .DATA_WIDTH (DW),
    .DIM        (D),
    .ITER_W     (IW),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .seed          (seed),
    .warmup        (warmup),
    .num_samples   (num_samples),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .eq_valid      (eq_valid),
    .eq_state      (eq_state),
    .eq_next_valid (eq_next_valid),
    .eq_next       (eq_next),
    .smp_valid     (smp_valid),
    .smp_ready     (smp_ready),
    .smp_data      (smp_data),
    .smp_index     (smp_index)
  );

  task automatic ck(input string nm, input logic [VW-1:0] act,
                    input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic ckn(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Each iteration adds one to every lane of the seed.
  function automatic logic [VW-1:0] model_smp(
    input logic [63:0] base, input logic [63:0] step,
    input int w, input int k);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++)
      v[lane_lsb(i, DW) +: DW] =
        base + 64'(i) * step + 64'(w) + 64'd1 + 64'(k);
    return v;
  endfunction

  // Core model, ready driver and protocol monitor.
  always @(negedge clk) begin
    if (res_pend) begin
      ckn("result_to_next", int'(eq_valid | smp_valid | done), 1);
      res_pend = 0;
    end
    if (hs_pend) begin
      ckn("handshake_to_next", int'(eq_valid | done), 1);
      hs_pend = 0;
    end
    if (prev_v && !prev_r && rst_n) begin
      ckn("hold_valid", int'(smp_valid), 1);
      ck("hold_data", smp_data, prev_d);
      ck("hold_index", VW'(smp_index), VW'(prev_i));
    end
    if (eq_valid) begin
      ev_cnt++;
      if (prev_ev) ckn("eqv_single_cycle", 1, 0);
    end
    if (done) done_cnt++;

    core_v = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0 && !core_mute) begin
        core_v = 1'b1;
        for (int i = 0; i < D; i++)
          core_data[lane_lsb(i, DW) +: DW] =
            core_hold[lane_lsb(i, DW) +: DW] + 64'd1;
      end
    end
    if (eq_valid) begin
      core_cnt = LAT;
      core_hold = eq_state;
    end
    if (core_v && busy) res_pend = 1;

    if (rdy_hold) smp_ready = 1'b0;
    else if (blk_left > 0 && smp_valid && int'(smp_index) == blk_idx) begin
      smp_ready = 1'b0;
      blk_left--;
    end else if (rdy_rand) smp_ready = 1'($urandom_range(0, 1));
    else smp_ready = 1'b1;

    if (smp_valid && smp_ready && rst_n) begin
      got_d.push_back(smp_data);
      got_i.push_back(smp_index);
      hs_pend = 1;
    end

    prev_v  = smp_valid && rst_n;
    prev_r  = smp_ready;
    prev_d  = smp_data;
    prev_i  = smp_index;
    prev_ev = eq_valid;
  end

  task automatic start_job(input logic [63:0] base, input logic [63:0] step,
                           input int w, input int n);
    for (int i = 0; i < D; i++)
      seed[lane_lsb(i, DW) +: DW] = base + 64'(i) * step;
    warmup = IW'(w);
    num_samples = IW'(n);
    got_d.delete();
    got_i.delete();
    ev_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ckn("start_busy", int'(busy), 1);
    ckn("start_eqv", int'(eq_valid), 1);
  endtask

  task automatic finish_job(input logic [63:0] base, input logic [63:0] step,
                            input int w, input int n, input int pulses);
    int lim;
    lim = 0;
    while (done_cnt == 0 && lim < 3000) begin
      @(negedge clk);
      lim++;
    end
    if (done_cnt == 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done");
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (10) @(negedge clk);
    ckn("n_samples", got_d.size(), n);
    for (int k = 0; k < got_d.size() && k < n; k++) begin
      ck("smp_data", got_d[k], model_smp(base, step, w, k));
      ckn("smp_index", int'(got_i[k]), k);
    end
    ckn("eqv_count", ev_cnt, pulses);
    ckn("done_count", done_cnt, 1);
    ckn("idle_busy", int'(busy), 0);
`ifndef CHAOS_ITER_TIMEOUT_EN
    ckn("err_tied", int'(err), 0);
`endif
  endtask

  task automatic wait_for(input bit want_eqv, input int idx);
    int lim;
    lim = 0;
    while (lim < 500) begin
      @(negedge clk);
      lim++;
      if (want_eqv && eq_valid && int'(smp_index) == idx) break;
      if (!want_eqv && smp_valid) break;
    end
    if (lim >= 500) begin
      total++;
      bad++;
      $display("FAIL wait_timeout: got no event want event %0d", idx);
    end
  endtask

  typedef struct {
    logic [63:0] base;
    logic [63:0] step;
    int          w;
    int          n;
    bit          rnd;
    int          exp_pulses;
    logic [63:0] exp_last;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{64'd0, 64'd0, 2, 3, 1'b0, 5, 64'd5};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0, 3, 1'b0, 3, 64'd1};
    tbl[2] = '{64'd10, 64'd3, 0, 1, 1'b0, 1, 64'd11};
    tbl[3] = '{64'd100, 64'd7, 4, 5, 1'b1, 9, 64'd109};

    @(negedge clk);
    ckn("rst_busy", int'(busy), 0);
    ckn("rst_done", int'(done), 0);
    ckn("rst_err", int'(err), 0);
    ckn("rst_eqv", int'(eq_valid), 0);
    ckn("rst_smpv", int'(smp_valid), 0);
    ck("rst_eq_state", eq_state, '0);
    ck("rst_smp_data", smp_data, '0);
    ck("rst_smp_index", VW'(smp_index), '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      rdy_rand = tbl[t].rnd;
      start_job(tbl[t].base, tbl[t].step, tbl[t].w, tbl[t].n);
      finish_job(tbl[t].base, tbl[t].step, tbl[t].w, tbl[t].n,
                 tbl[t].exp_pulses);
      if (got_d.size() > 0)
        ck("last_lane0", VW'(got_d[got_d.size()-1][63:0]),
           VW'(tbl[t].exp_last));
    end
    rdy_rand = 0;

    blk_idx = 1;
    blk_left = 4;
    start_job(64'h1000, 64'h10, 1, 3);
    finish_job(64'h1000, 64'h10, 1, 3, 4);
    ckn("backpressure_used", blk_left, 0);

    start_job(64'd0, 64'd1, 1, 0);
    wait_for(1'b1, 6);
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    finish_job(64'd0, 64'd1, 1, 7, 8);

    rdy_hold = 1;
    start_job(64'd50, 64'd2, 1, 3);
    wait_for(1'b0, 0);
    seed = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stray_data = '1;
    stray_v = 1'b1;
    @(negedge clk);
    stray_v = 1'b0;
    repeat (2) @(negedge clk);
    ck("ignored_hold", smp_data, model_smp(64'd50, 64'd2, 1, 0));
    rdy_hold = 0;
    finish_job(64'd50, 64'd2, 1, 3, 4);

    start_job(64'd7, 64'd1, 3, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    ckn("mid_rst_busy", int'(busy), 0);
    ckn("mid_rst_eqv", int'(eq_valid), 0);
    ckn("mid_rst_smpv", int'(smp_valid), 0);
    ckn("mid_rst_done", int'(done), 0);
    ck("mid_rst_state", eq_state, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    ckn("late_busy", int'(busy), 0);
    ckn("late_smpv", int'(smp_valid), 0);
    ck("late_state", eq_state, '0);
    ckn("late_eqv_count", ev_cnt, 1);

    for (int r = 0; r < 6; r++) begin
      logic [63:0] b;
      logic [63:0] s;
      int w;
      int n;
      b = {$urandom, $urandom};
      s = 64'($urandom_range(0, 3));
      w = int'($urandom_range(0, 5));
      n = int'($urandom_range(1, 6));
      rdy_rand = 1;
      start_job(b, s, w, n);
      finish_job(b, s, w, n, w + n);
    end
    rdy_rand = 0;

`ifdef CHAOS_ITER_TIMEOUT_EN
    begin
      int cyc;
      core_mute = 1'b1;
      start_job(64'd0, 64'd1, 0, 1);
      cyc = 0;
      while (!done && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      ckn("wdog_done_delay", cyc, TO + 1);
      ckn("wdog_err", int'(err), 1);
      core_mute = 1'b0;
      repeat (8) @(negedge clk);
      ckn("wdog_err_sticky", int'(err), 1);
      start_job(64'd20, 64'd1, 0, 2);
      ckn("wdog_err_cleared", int'(err), 0);
      finish_job(64'd20, 64'd1, 0, 2, 2);
      ckn("wdog_err_after", int'(err), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
